tile_spawn_controller: RTL and testbench
========================================

# tile_spawn_controller

Sequences new-tile placement for the 2048 board: on a spawn request it samples the free-running position and value counters, finds the first empty cell at or after the sampled position, and issues a single-cycle board write with tile exponent 1 (value 2) or 2 (value 4). It sits between the move/merge logic, which raises `spawn_req` after every valid move, and the board register file. It also reports a full board so the game-over logic can react.

## Interface

Parameters:
- `FOUR_THRESHOLD`, default 14: a sampled `rand_val` >= this value spawns a 4. Otherwise the block spawns a 2. Range 0..15; 16 or more is not legal.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `spawn_req`  in  1  request one spawn; level, sampled only in IDLE.
- `empty_mask`  in  16  bit i = 1 means cell i is empty; row-major, cell 0 top-left.
- `rand_pos`  in  4  position counter value (counter stepping by 1).
- `rand_val`  in  4  value counter value (counter stepping by 2).
- `busy`  out  1  high while a request is in progress.
- `write_en`  out  1  one-cycle board write strobe.
- `cell_idx`  out  4  target cell; meaningful when `write_en`=1.
- `tile_exp`  out  4  tile exponent to write: 1 or 2; meaningful when `write_en`=1.
- `done`  out  1  one-cycle end-of-request pulse, for both success and full.
- `full`  out  1  one-cycle pulse together with `done` when no empty cell exists.
- `spawn_count`  out  8  number of successful spawns since reset; wraps 255 -> 0.

## Operation

- States are IDLE, SCAN, WRITE and FULL.
- IDLE, when `spawn_req`=1:
  - latch `ptr <= rand_pos`, `scan_cnt <= 0`;
  - latch `exp_q <= (rand_val >= FOUR_THRESHOLD) ? 2 : 1`;
  - go to SCAN.
- SCAN checks one cell per cycle:
  - if `empty_mask[ptr]`=1, go to WRITE with `cell_idx_q <= ptr`;
  - else if `scan_cnt`=15, go to FULL;
  - else `ptr <= ptr+1` (mod 16, so 15 wraps to 0) and `scan_cnt <= scan_cnt+1`.
- WRITE:
  - `write_en`=1, `done`=1, `cell_idx`=`cell_idx_q`, `tile_exp`=`exp_q`;
  - `spawn_count <= spawn_count+1`;
  - go to IDLE.
- FULL:
  - `done`=1, `full`=1, `write_en`=0;
  - `spawn_count` unchanged;
  - go to IDLE.
- `busy` = 1 in SCAN, WRITE and FULL; 0 in IDLE.
- `spawn_req` outside IDLE is ignored and not queued. If it is still high when the block returns to IDLE, a new request is accepted in that cycle.
- The upstream logic must hold `empty_mask` stable while `busy`=1. The block reads it live during SCAN.
- `rand_pos` and `rand_val` are read only in the IDLE acceptance cycle. Later counter changes have no effect on a request in progress.
- `cell_idx` and `tile_exp` are 0 whenever `write_en`=0.
- Reset value of every output is 0. The state returns to IDLE.
- Reset mid-request aborts the request: no `write_en`, no `done`, and `spawn_count` is cleared.

## Timing

- Request accepted at cycle N (IDLE with `spawn_req`=1).
- SCAN checks the k-th candidate (k=0..15) at cycle N+1+k.
- First empty cell found at candidate k: `write_en`/`done` high at cycle N+2+k, and the block is back in IDLE at N+3+k.
  - Best-case latency, start cell empty: 2 cycles from acceptance to `write_en`.
  - Worst case, only empty cell at candidate 15: 17 cycles.
- Board full: `done`/`full` high at cycle N+17.
- `spawn_count` shows the new value in the cycle after `write_en`.
- Back-to-back: with `spawn_req` held high, the next acceptance is at the cycle after `done`. The minimum request period is 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan

- Reset, then `empty_mask`=16'hFFFF, `rand_pos`=5, `rand_val`=3, one-cycle `spawn_req` -> `write_en` 2 cycles after acceptance, `cell_idx`=5, `tile_exp`=1, `done`=1, `full`=0, `spawn_count`=1.
- `empty_mask`=16'h0004, `rand_pos`=14, `rand_val`=15 -> scan covers 14, 15, 0, 1, 2 (wrap-around); `write_en` at N+6, `cell_idx`=2, `tile_exp`=2.
- `empty_mask`=16'h0000, any `rand_pos` -> no `write_en`; `done`=`full`=1 at N+17; `busy` high N+1..N+17; `spawn_count` unchanged.
- `spawn_req` pulsed again while busy, and `rand_pos` changed mid-scan -> ignored; exactly one `write_en` per accepted request, at the originally latched position.
- `reset` asserted at N+3 of a long scan -> all outputs 0 next cycle, no `write_en` ever, `spawn_count`=0; a new request then completes normally.
- 256 successful spawns with `spawn_req` held high -> `spawn_count` wraps to 0; successive `write_en` pulses at least 3 cycles apart; `rand_val`=13 vs 14 gives `tile_exp`=1 vs 2 at `FOUR_THRESHOLD`=14.

Source files
------------

// File: rtl/tile_spawn_controller.sv
// New-tile placement sequencer for the 2048 board: latches a random start cell and value,
// scans for the first empty cell and issues a single-cycle board write, or reports a full board.
//
// state | meaning
// IDLE  | waiting for spawn_req; latches rand_pos / rand_val on acceptance
// SCAN  | tests one candidate cell per cycle, wrapping 15 -> 0
// WRITE | one-cycle board write strobe with done
// FULL  | one-cycle done + full pulse, no write
module tile_spawn_controller #(
    parameter int unsigned FOUR_THRESHOLD = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spawn_req,
    input  logic [15:0] empty_mask,
    input  logic [3:0]  rand_pos,
    input  logic [3:0]  rand_val,
    output logic        busy,
    output logic        write_en,
    output logic [3:0]  cell_idx,
    output logic [3:0]  tile_exp,
    output logic        done,
    output logic        full,
    output logic [7:0]  spawn_count
);

    localparam logic [4:0] THRESH = FOUR_THRESHOLD[4:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]  exp_q, exp_d;
    logic [3:0]  cell_idx_q, cell_idx_d;
    logic [7:0]  spawn_count_q, spawn_count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            scan_cnt_q    <= '0;
            exp_q         <= '0;
            cell_idx_q    <= '0;
            spawn_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            scan_cnt_q    <= scan_cnt_d;
            exp_q         <= exp_d;
            cell_idx_q    <= cell_idx_d;
            spawn_count_q <= spawn_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        scan_cnt_d    = scan_cnt_q;
        exp_d         = exp_q;
        cell_idx_d    = cell_idx_q;
        spawn_count_d = spawn_count_q;

        unique case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    ptr_d      = rand_pos;
                    scan_cnt_d = '0;
                    exp_d      = ({1'b0, rand_val} >= THRESH) ? 2'd2 : 2'd1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // empty_mask is read live; upstream keeps it stable while busy
                if (empty_mask[ptr_q]) begin
                    cell_idx_d = ptr_q;
                    state_d    = WRITE;
                end else if (scan_cnt_q == 4'd15) begin
                    state_d = FULL;
                end else begin
                    ptr_d      = ptr_q + 4'd1;
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
            end
            WRITE: begin
                spawn_count_d = spawn_count_q + 8'd1;
                state_d       = IDLE;
            end
            FULL: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state and registers only
    assign busy        = (state_q != IDLE);
    assign write_en    = (state_q == WRITE);
    assign done        = (state_q == WRITE) || (state_q == FULL);
    assign full        = (state_q == FULL);
    assign cell_idx    = write_en ? cell_idx_q : 4'd0;
    assign tile_exp    = write_en ? {2'b00, exp_q} : 4'd0;
    assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_tile_spawn_controller.sv
// Self-checking bench for tile_spawn_controller: directed and randomized requests compared
// against a first-empty-cell search model computed from the placement rules.
module tb_tile_spawn_controller;

    localparam int unsigned THR = 14;

    logic        clock;
    logic        reset;
    logic        spawn_req;
    logic [15:0] empty_mask;
    logic [3:0]  rand_pos;
    logic [3:0]  rand_val;
    logic        busy;
    logic        write_en;
    logic [3:0]  cell_idx;
    logic [3:0]  tile_exp;
    logic        done;
    logic        full;
    logic [7:0]  spawn_count;

    int n_checks = 0;
    int n_fail   = 0;
    int model_count = 0;

    tile_spawn_controller #(.FOUR_THRESHOLD(THR)) dut (
        .clock       (clock),
        .reset       (reset),
        .spawn_req   (spawn_req),
        .empty_mask  (empty_mask),
        .rand_pos    (rand_pos),
        .rand_val    (rand_val),
        .busy        (busy),
        .write_en    (write_en),
        .cell_idx    (cell_idx),
        .tile_exp    (tile_exp),
        .done        (done),
        .full        (full),
        .spawn_count (spawn_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     busy,        0);
        check({tag, "_write_en"}, write_en,    0);
        check({tag, "_cell_idx"}, cell_idx,    0);
        check({tag, "_tile_exp"}, tile_exp,    0);
        check({tag, "_done"},     done,        0);
        check({tag, "_full"},     full,        0);
        check({tag, "_count"},    spawn_count, 0);
    endtask

    // One request from an idle cycle; optional noise on spawn_req / counters while busy.
    task automatic run_req(input string tag, input logic [15:0] mask, input logic [3:0] pos,
                           input logic [3:0] val, input bit noise);
        int k, e, n_we, n_done, we_cyc, done_cyc, full_cyc, idle_cyc;
        int exp_cell, exp_exp;
        logic [3:0] got_cell, got_exp;
        bit zero_ok;
        k = -1;
        for (int i = 0; i < 16; i++)
            if (k < 0 && mask[(int'(pos) + i) % 16]) k = i;
        e        = (k >= 0) ? 2 + k : 17;
        exp_cell = (k >= 0) ? (int'(pos) + k) % 16 : 0;
        exp_exp  = (int'(val) >= int'(THR)) ? 2 : 1;
        n_we = 0; n_done = 0; we_cyc = 0; done_cyc = 0; full_cyc = 0; idle_cyc = 0;
        got_cell = 0; got_exp = 0; zero_ok = 1;

        check({tag, "_idle_before"}, busy, 0);
        empty_mask = mask;
        rand_pos   = pos;
        rand_val   = val;
        spawn_req  = 1'b1;
        step();
        spawn_req  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!busy) begin
                idle_cyc = c;
                break;
            end
            if (write_en) begin
                n_we++;
                we_cyc   = c;
                got_cell = cell_idx;
                got_exp  = tile_exp;
            end else if (cell_idx != 4'd0 || tile_exp != 4'd0) begin
                zero_ok = 0;
            end
            if (done) begin n_done++; done_cyc = c; end
            if (full) full_cyc = c;
            if (noise) begin
                spawn_req = 1'($urandom_range(0, 1));
                rand_pos  = 4'($urandom);
                rand_val  = 4'($urandom);
            end
            step();
        end
        spawn_req = 1'b0;
        if (k >= 0) model_count = (model_count + 1) % 256;

        check({tag, "_idle_cycle"}, idle_cyc, e + 1);
        check({tag, "_done_cycle"}, done_cyc, e);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_we_count"},   n_we, (k >= 0) ? 1 : 0);
        check({tag, "_full_cycle"}, full_cyc, (k >= 0) ? 0 : e);
        check({tag, "_idle_zero"},  zero_ok, 1);
        if (k >= 0) begin
            check({tag, "_we_cycle"}, we_cyc, e);
            check({tag, "_cell_idx"}, got_cell, exp_cell);
            check({tag, "_tile_exp"}, got_exp, exp_exp);
        end
        check({tag, "_spawn_count"}, spawn_count, model_count);
    endtask

    initial begin
        int lat_pos, lat_val, last_we, n_we, ridle;
        bit finished, quiet;
        logic [15:0] m;

        reset = 1'b1; spawn_req = 1'b0; empty_mask = '0; rand_pos = '0; rand_val = '0;
        step(); step(); step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        run_req("t1_first_cell", 16'hFFFF, 4'd5, 4'd3, 1'b0);
        run_req("t2_wrap", 16'h0004, 4'd14, 4'd15, 1'b0);
        run_req("t3_full", 16'h0000, 4'($urandom), 4'($urandom), 1'b0);
        run_req("t4_last_cand", 16'h0010, 4'd5, 4'd0, 1'b0);
        run_req("t5_val13", 16'h0100, 4'd8, 4'd13, 1'b0);
        run_req("t6_val14", 16'h0100, 4'd8, 4'd14, 1'b0);
        run_req("t7_noise_full", 16'h0000, 4'd3, 4'd7, 1'b1);

        for (int r = 0; r < 40; r++) begin
            m = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if (r % 8 == 0) m = 16'h0000;
            run_req("rand", m, 4'($urandom), 4'($urandom), 1'b1);
        end

        // reset in the middle of a long scan
        empty_mask = 16'h0001; rand_pos = 4'd1; rand_val = 4'd15;
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("mid_reset");
        model_count = 0;
        quiet = 1;
        for (int c = 0; c < 20; c++) begin
            if (busy || write_en || done || full || spawn_count != 8'd0) quiet = 0;
            step();
        end
        check("mid_reset_quiet", quiet, 1);
        run_req("after_reset", 16'h0001, 4'd1, 4'd2, 1'b0);

        // 256 spawns back to back with spawn_req held high
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_count = 0;
        empty_mask = 16'hFFFF;
        spawn_req  = 1'b1;
        last_we = -100; n_we = 0; finished = 0; lat_pos = 0; lat_val = 0; ridle = 0;
        for (int t = 0; t < 900 && !finished; t++) begin
            if (write_en) begin
                if (n_we > 0) check("hold_gap", t - last_we, 3);
                check("hold_cell", cell_idx, lat_pos);
                check("hold_exp", tile_exp, (lat_val >= int'(THR)) ? 2 : 1);
                last_we = t;
                n_we++;
                model_count = (model_count + 1) % 256;
            end
            rand_pos = 4'($urandom);
            rand_val = 4'($urandom);
            if (!busy) begin
                ridle++;
                if (ridle > 1) check("hold_count", spawn_count, model_count);
                if (n_we == 256) begin
                    finished  = 1;
                    spawn_req = 1'b0;
                end else begin
                    lat_pos = int'(rand_pos);
                    lat_val = int'(rand_val);
                end
            end
            if (!finished) step();
        end
        check("hold_finished", finished, 1);
        check("hold_wrap", spawn_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
